// File: rtl/video_ctrl_pkg.sv
// Shared definitions for the video frame scheduler.
//   DefDw / DefLw : default TDATA width and line-count width
//   SrcPattern / SrcBt656 : source-select encoding (s0 / s1)
//   sched_state_e : scheduler FSM states
package video_ctrl_pkg;

   localparam int unsigned DefDw = 16;
   localparam int unsigned DefLw = 12;

   localparam logic SrcPattern = 1'b0;
   localparam logic SrcBt656   = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StWaitSof,
      StPass,
      StHold
   } sched_state_e;

endpackage

// File: rtl/video_axis_reg.sv
// Single-stage AXI4-stream register slice for video beats.
// Ports:
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   i_valid/o_ready/i_data/i_user/i_last : upstream beat
//   o_valid/i_ready/o_data/o_user/o_last : registered downstream beat
// Payload is only rewritten on a load, so it stays stable while stalled.
module video_axis_reg
   import video_ctrl_pkg::*;
#(
   parameter int unsigned DW = DefDw
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [DW-1:0] i_data,
   input  logic          i_user,
   input  logic          i_last,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [DW-1:0] o_data,
   output logic          o_user,
   output logic          o_last
);

   logic          r_valid;
   logic [DW-1:0] r_data;
   logic          r_user;
   logic          r_last;
   logic          w_load;

   assign o_ready = !r_valid || i_ready;
   assign w_load  = i_valid && o_ready;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_user  <= 1'b0;
         r_last  <= 1'b0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_user  <= i_user;
         r_last  <= i_last;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_user  = r_user;
   assign o_last  = r_last;

endmodule

// File: rtl/video_frame_sched.sv
// Video frame scheduler: selects one of two AXI4-stream video sources, aligns to
// start-of-frame, forwards whole frames through a one-cycle register stage and
// keeps frame / short-frame statistics.
// Ports:
//   ACLK, ARESETn                     : clock, synchronous active-low reset
//   cfg_*                             : enable, single-shot mode, source select,
//                                       frames per shot, lines per frame
//   s0_* / s1_*                       : pattern / BT656 source slaves
//   m_*                               : video master (tuser = SOF, tlast = EOL)
//   sts_*                             : busy, frame count, error count, done pulse
module video_frame_sched
   import video_ctrl_pkg::*;
#(
   parameter int unsigned DW = DefDw,
   parameter int unsigned LW = DefLw
) (
   input  logic          ACLK,
   input  logic          ARESETn,
   input  logic          cfg_en_i,
   input  logic          cfg_single_i,
   input  logic          cfg_src_sel_i,
   input  logic [15:0]   cfg_frames_i,
   input  logic [LW-1:0] cfg_lines_i,
   input  logic [DW-1:0] s0_tdata_i,
   input  logic          s0_tvalid_i,
   input  logic          s0_tuser_i,
   input  logic          s0_tlast_i,
   output logic          s0_tready_o,
   input  logic [DW-1:0] s1_tdata_i,
   input  logic          s1_tvalid_i,
   input  logic          s1_tuser_i,
   input  logic          s1_tlast_i,
   output logic          s1_tready_o,
   output logic [DW-1:0] m_tdata_o,
   output logic          m_tvalid_o,
   output logic          m_tuser_o,
   output logic          m_tlast_o,
   input  logic          m_tready_i,
   output logic          sts_busy_o,
   output logic [15:0]   sts_frame_cnt_o,
   output logic [7:0]    sts_err_cnt_o,
   output logic          sts_done_o
);

   sched_state_e  r_state, w_state_nxt;
   logic          r_sel, w_sel_nxt;
   logic          r_single, w_single_nxt;
   logic [15:0]   r_frames, w_frames_nxt;
   logic [LW-1:0] r_lines, w_lines_nxt;
   logic [LW-1:0] r_line_cnt, w_line_cnt_nxt, w_line_base;
   logic [15:0]   r_frame_cnt, w_frame_cnt_nxt;
   logic [7:0]    r_err_cnt, w_err_cnt_nxt;
   logic          r_done, w_done_nxt;

   logic          w_src_valid, w_src_user, w_src_last;
   logic [DW-1:0] w_src_data;
   logic          w_out_rdy, w_sel_active, w_accept, w_fwd;

   assign w_src_valid = (r_sel == SrcBt656) ? s1_tvalid_i : s0_tvalid_i;
   assign w_src_user  = (r_sel == SrcBt656) ? s1_tuser_i  : s0_tuser_i;
   assign w_src_last  = (r_sel == SrcBt656) ? s1_tlast_i  : s0_tlast_i;
   assign w_src_data  = (r_sel == SrcBt656) ? s1_tdata_i  : s0_tdata_i;

   // Only the selected source in WAIT_SOF/PASS is back-pressured; everything
   // else free-runs into the bit bucket.
   assign w_sel_active = (r_state == StWaitSof) || (r_state == StPass);
   assign s0_tready_o  = (w_sel_active && (r_sel == SrcPattern)) ? w_out_rdy : 1'b1;
   assign s1_tready_o  = (w_sel_active && (r_sel == SrcBt656))   ? w_out_rdy : 1'b1;
   assign w_accept     = w_sel_active && w_src_valid && w_out_rdy;

   always_comb begin
      w_state_nxt     = r_state;
      w_sel_nxt       = r_sel;
      w_single_nxt    = r_single;
      w_frames_nxt    = r_frames;
      w_lines_nxt     = r_lines;
      w_line_cnt_nxt  = r_line_cnt;
      w_frame_cnt_nxt = r_frame_cnt;
      w_err_cnt_nxt   = r_err_cnt;
      w_done_nxt      = 1'b0;
      w_fwd           = 1'b0;
      w_line_base     = r_line_cnt;

      unique case (r_state)
         StIdle: begin
            if (cfg_en_i) begin
               w_state_nxt     = StWaitSof;
               w_sel_nxt       = cfg_src_sel_i;
               w_single_nxt    = cfg_single_i;
               w_frames_nxt    = (cfg_frames_i == 16'd0) ? 16'd1 : cfg_frames_i;
               w_lines_nxt     = (cfg_lines_i == '0) ? LW'(1) : cfg_lines_i;
               w_frame_cnt_nxt = '0;
               w_line_cnt_nxt  = '0;
            end
         end
         StWaitSof: begin
            // Non-SOF beats are accepted and silently dropped.
            if (w_accept && w_src_user) begin
               w_fwd       = 1'b1;
               w_line_base = '0;
            end
         end
         StPass: begin
            if (w_accept) begin
               w_fwd = 1'b1;
               // SOF inside a frame: restart the frame and log a short frame.
               if (w_src_user) begin
                  w_line_base = '0;
                  if (r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;
               end
            end
         end
         StHold: begin
            if (!cfg_en_i) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase

      // Line / frame bookkeeping happens on input acceptance.
      if (w_fwd) begin
         w_state_nxt    = StPass;
         w_line_cnt_nxt = w_line_base;
         if (w_src_last) begin
            if (w_line_base == r_lines - LW'(1)) begin
               w_frame_cnt_nxt = r_frame_cnt + 16'd1;
               w_line_cnt_nxt  = '0;
               if (!cfg_en_i) begin
                  w_state_nxt = StIdle;
               end else if (r_single && ((r_frame_cnt + 16'd1) == r_frames)) begin
                  w_state_nxt = StHold;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = StWaitSof;
                  w_sel_nxt   = cfg_src_sel_i;
               end
            end else begin
               w_line_cnt_nxt = w_line_base + LW'(1);
            end
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         r_state     <= StIdle;
         r_sel       <= SrcPattern;
         r_single    <= 1'b0;
         r_frames    <= 16'd1;
         r_lines     <= LW'(1);
         r_line_cnt  <= '0;
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sel       <= w_sel_nxt;
         r_single    <= w_single_nxt;
         r_frames    <= w_frames_nxt;
         r_lines     <= w_lines_nxt;
         r_line_cnt  <= w_line_cnt_nxt;
         r_frame_cnt <= w_frame_cnt_nxt;
         r_err_cnt   <= w_err_cnt_nxt;
         r_done      <= w_done_nxt;
      end
   end

   video_axis_reg #(
      .DW (DW)
   ) u_out_reg (
      .i_clk   (ACLK),
      .i_rst_n (ARESETn),
      .i_valid (w_fwd),
      .o_ready (w_out_rdy),
      .i_data  (w_src_data),
      .i_user  (w_src_user),
      .i_last  (w_src_last),
      .o_valid (m_tvalid_o),
      .i_ready (m_tready_i),
      .o_data  (m_tdata_o),
      .o_user  (m_tuser_o),
      .o_last  (m_tlast_o)
   );

   assign sts_busy_o      = (r_state != StIdle);
   assign sts_frame_cnt_o = r_frame_cnt;
   assign sts_err_cnt_o   = r_err_cnt;
   assign sts_done_o      = r_done;

endmodule

// File: tb/tb_video_frame_sched.sv
// Directed bench for video_frame_sched. Beats are encoded {tuser, tlast, tdata}.
module tb_video_frame_sched;

   localparam int DW = 16;
   localparam int LW = 12;

   logic          ACLK;
   logic          ARESETn;
   logic          cfg_en_i, cfg_single_i, cfg_src_sel_i;
   logic [15:0]   cfg_frames_i;
   logic [LW-1:0] cfg_lines_i;
   logic [DW-1:0] s0_tdata_i, s1_tdata_i;
   logic          s0_tvalid_i, s0_tuser_i, s0_tlast_i, s0_tready_o;
   logic          s1_tvalid_i, s1_tuser_i, s1_tlast_i, s1_tready_o;
   logic [DW-1:0] m_tdata_o;
   logic          m_tvalid_o, m_tuser_o, m_tlast_o, m_tready_i;
   logic          sts_busy_o, sts_done_o;
   logic [15:0]   sts_frame_cnt_o;
   logic [7:0]    sts_err_cnt_o;

   int            n_vec = 0;
   int            n_err = 0;
   bit            g_rand_rdy = 0;
   logic [17:0]   mq[$];
   logic [17:0]   eq[$];
   bit            hold_v = 0;
   logic [17:0]   hold_d;

   video_frame_sched #(
      .DW (DW),
      .LW (LW)
   ) dut (
      .ACLK            (ACLK),
      .ARESETn         (ARESETn),
      .cfg_en_i        (cfg_en_i),
      .cfg_single_i    (cfg_single_i),
      .cfg_src_sel_i   (cfg_src_sel_i),
      .cfg_frames_i    (cfg_frames_i),
      .cfg_lines_i     (cfg_lines_i),
      .s0_tdata_i      (s0_tdata_i),
      .s0_tvalid_i     (s0_tvalid_i),
      .s0_tuser_i      (s0_tuser_i),
      .s0_tlast_i      (s0_tlast_i),
      .s0_tready_o     (s0_tready_o),
      .s1_tdata_i      (s1_tdata_i),
      .s1_tvalid_i     (s1_tvalid_i),
      .s1_tuser_i      (s1_tuser_i),
      .s1_tlast_i      (s1_tlast_i),
      .s1_tready_o     (s1_tready_o),
      .m_tdata_o       (m_tdata_o),
      .m_tvalid_o      (m_tvalid_o),
      .m_tuser_o       (m_tuser_o),
      .m_tlast_o       (m_tlast_o),
      .m_tready_i      (m_tready_i),
      .sts_busy_o      (sts_busy_o),
      .sts_frame_cnt_o (sts_frame_cnt_o),
      .sts_err_cnt_o   (sts_err_cnt_o),
      .sts_done_o      (sts_done_o)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Output capture plus hold-stability check while stalled.
   always @(posedge ACLK) begin
      if (!ARESETn) begin
         hold_v = 0;
      end else begin
         if (hold_v) begin
            n_vec++;
            if (m_tvalid_o !== 1'b1 || {m_tuser_o, m_tlast_o, m_tdata_o} !== hold_d) begin
               n_err++;
               $display("FAIL stall_stable: got v=%b %h, required v=1 %h", m_tvalid_o,
                        {m_tuser_o, m_tlast_o, m_tdata_o}, hold_d);
            end
         end
         if (m_tvalid_o && m_tready_i) mq.push_back({m_tuser_o, m_tlast_o, m_tdata_o});
         hold_v = m_tvalid_o && !m_tready_i;
         hold_d = {m_tuser_o, m_tlast_o, m_tdata_o};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge ACLK);
         #1;
      end
   endtask

   // Present one beat on a source and wait until it is accepted.
   task automatic send_beat(input bit src, input logic [15:0] d, input bit u, input bit l,
                            input bit fwd);
      bit ok = 0;
      int n  = 0;
      if (src) begin
         s1_tdata_i = d; s1_tuser_i = u; s1_tlast_i = l; s1_tvalid_i = 1'b1;
      end else begin
         s0_tdata_i = d; s0_tuser_i = u; s0_tlast_i = l; s0_tvalid_i = 1'b1;
      end
      while (!ok) begin
         if (g_rand_rdy) m_tready_i = 1'($urandom_range(0, 1));
         #1;
         ok = src ? s1_tready_o : s0_tready_o;
         @(posedge ACLK);
         #1;
         n++;
         if (!ok && n > 200) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: beat %h not accepted, required accept in 200", d);
            break;
         end
      end
      if (fwd) eq.push_back({u, l, d});
      if (src) s1_tvalid_i = 1'b0;
      else     s0_tvalid_i = 1'b0;
   endtask

   task automatic send_frame(input bit src, input int nl, input int ppl,
                             input logic [15:0] base, input bit fwd, input int drop_en_line);
      for (int ln = 0; ln < nl; ln++) begin
         if (ln == drop_en_line) cfg_en_i = 1'b0;
         for (int p = 0; p < ppl; p++)
            send_beat(src, base + 16'(ln * ppl + p), (ln == 0 && p == 0), (p == ppl - 1), fwd);
      end
   endtask

   task automatic test_reset;
      ARESETn = 1'b0;
      s0_tvalid_i = 1'b1; s0_tuser_i = 1'b1; s0_tdata_i = 16'hDEAD;
      cfg_en_i = 1'b1;
      tick(3);
      n_vec++;
      if ({m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o} !== 19'd0) begin
         n_err++;
         $display("FAIL reset_out: got %h, required 0", {m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o});
      end
      n_vec++;
      if ({sts_busy_o, sts_done_o, sts_frame_cnt_o, sts_err_cnt_o} !== 26'd0) begin
         n_err++;
         $display("FAIL reset_sts: got %h, required 0",
                  {sts_busy_o, sts_done_o, sts_frame_cnt_o, sts_err_cnt_o});
      end
      n_vec++;
      if ({s0_tready_o, s1_tready_o} !== 2'b11) begin
         n_err++;
         $display("FAIL reset_tready: got %b, required 11", {s0_tready_o, s1_tready_o});
      end
      s0_tvalid_i = 1'b0; s0_tuser_i = 1'b0; cfg_en_i = 1'b0;
      ARESETn = 1'b1;
      tick(1);
   endtask

   task automatic test_continuous;
      mq.delete(); eq.delete();
      cfg_single_i = 1'b0; cfg_src_sel_i = 1'b0; cfg_lines_i = 12'd4; cfg_en_i = 1'b1;
      tick(1);
      send_beat(0, 16'h1000, 1, 0, 1);
      n_vec++;
      if ({m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o} !== {3'b110, 16'h1000}) begin
         n_err++;
         $display("FAIL cont_latency: got %h, required %h",
                  {m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o}, {3'b110, 16'h1000});
      end
      send_beat(0, 16'h1001, 0, 1, 1);
      for (int ln = 1; ln < 4; ln++) begin
         send_beat(0, 16'h1000 + 16'(2 * ln), 0, 0, 1);
         send_beat(0, 16'h1001 + 16'(2 * ln), 0, 1, 1);
      end
      n_vec++;
      if (sts_frame_cnt_o !== 16'd1) begin
         n_err++; $display("FAIL cont_frame1: got %0d, required 1", sts_frame_cnt_o);
      end
      send_frame(0, 4, 2, 16'h1100, 1, -1);
      n_vec++;
      if (sts_frame_cnt_o !== 16'd2) begin
         n_err++; $display("FAIL cont_frame2: got %0d, required 2", sts_frame_cnt_o);
      end
      send_frame(0, 4, 2, 16'h1200, 1, 2);
      n_vec++;
      if (sts_frame_cnt_o !== 16'd3 || sts_busy_o !== 1'b0 || sts_err_cnt_o !== 8'd0) begin
         n_err++;
         $display("FAIL cont_frame3: got cnt=%0d busy=%b err=%0d, required 3 0 0",
                  sts_frame_cnt_o, sts_busy_o, sts_err_cnt_o);
      end
      tick(1);
      n_vec++;
      if (mq.size() != 24) begin
         n_err++; $display("FAIL cont_count: got %0d beats, required 24", mq.size());
      end else begin
         foreach (eq[i]) begin
            n_vec++;
            if (mq[i] !== eq[i]) begin
               n_err++; $display("FAIL cont_beat%0d: got %h, required %h", i, mq[i], eq[i]);
            end
         end
      end
   endtask

   task automatic test_single;
      mq.delete(); eq.delete();
      cfg_single_i = 1'b1; cfg_frames_i = 16'd2; cfg_lines_i = 12'd2; cfg_en_i = 1'b1;
      tick(1);
      n_vec++;
      if (sts_frame_cnt_o !== 16'd0 || sts_busy_o !== 1'b1) begin
         n_err++;
         $display("FAIL single_start: got cnt=%0d busy=%b, required 0 1", sts_frame_cnt_o, sts_busy_o);
      end
      send_frame(0, 2, 2, 16'h2000, 1, -1);
      n_vec++;
      if (sts_done_o !== 1'b0 || sts_frame_cnt_o !== 16'd1) begin
         n_err++;
         $display("FAIL single_f1: got done=%b cnt=%0d, required 0 1", sts_done_o, sts_frame_cnt_o);
      end
      send_frame(0, 2, 2, 16'h2100, 1, -1);
      n_vec++;
      if (sts_done_o !== 1'b1 || sts_busy_o !== 1'b1 || sts_frame_cnt_o !== 16'd2) begin
         n_err++;
         $display("FAIL single_f2: got done=%b busy=%b cnt=%0d, required 1 1 2",
                  sts_done_o, sts_busy_o, sts_frame_cnt_o);
      end
      tick(1);
      n_vec++;
      if (sts_done_o !== 1'b0 || sts_busy_o !== 1'b1) begin
         n_err++;
         $display("FAIL single_pulse: got done=%b busy=%b, required 0 1", sts_done_o, sts_busy_o);
      end
      send_frame(0, 2, 2, 16'h2200, 0, -1);
      tick(1);
      n_vec++;
      if (mq.size() != 8 || sts_frame_cnt_o !== 16'd2 || sts_busy_o !== 1'b1) begin
         n_err++;
         $display("FAIL single_hold: got beats=%0d cnt=%0d busy=%b, required 8 2 1",
                  mq.size(), sts_frame_cnt_o, sts_busy_o);
      end else begin
         foreach (eq[i]) begin
            n_vec++;
            if (mq[i] !== eq[i]) begin
               n_err++; $display("FAIL single_beat%0d: got %h, required %h", i, mq[i], eq[i]);
            end
         end
      end
      cfg_en_i = 1'b0;
      tick(1);
      n_vec++;
      if (sts_busy_o !== 1'b0) begin
         n_err++; $display("FAIL single_idle: got busy=%b, required 0", sts_busy_o);
      end
      // frames=0 behaves as a one-frame shot
      cfg_frames_i = 16'd0; cfg_en_i = 1'b1;
      tick(1);
      send_frame(0, 2, 2, 16'h2300, 0, -1);
      n_vec++;
      if (sts_done_o !== 1'b1 || sts_frame_cnt_o !== 16'd1) begin
         n_err++;
         $display("FAIL single_zero: got done=%b cnt=%0d, required 1 1", sts_done_o, sts_frame_cnt_o);
      end
      cfg_en_i = 1'b0; cfg_single_i = 1'b0;
      tick(2);
   endtask

   task automatic test_mid_enable;
      mq.delete(); eq.delete();
      cfg_src_sel_i = 1'b1; cfg_lines_i = 12'd2; cfg_en_i = 1'b1;
      tick(1);
      send_beat(1, 16'h3AA0, 0, 0, 0);
      send_beat(1, 16'h3AA1, 0, 1, 0);
      n_vec++;
      if (m_tvalid_o !== 1'b0) begin
         n_err++; $display("FAIL midena_drop: got m_tvalid=%b, required 0", m_tvalid_o);
      end
      send_frame(1, 2, 2, 16'h3000, 1, 1);
      tick(1);
      n_vec++;
      if (mq.size() != 4 || sts_busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL midena_count: got beats=%0d busy=%b, required 4 0", mq.size(), sts_busy_o);
      end else begin
         n_vec++;
         if (mq[0] !== {2'b10, 16'h3000}) begin
            n_err++; $display("FAIL midena_sof: got %h, required %h", mq[0], {2'b10, 16'h3000});
         end
         foreach (eq[i]) begin
            n_vec++;
            if (mq[i] !== eq[i]) begin
               n_err++; $display("FAIL midena_beat%0d: got %h, required %h", i, mq[i], eq[i]);
            end
         end
      end
   endtask

   task automatic test_src_switch;
      mq.delete(); eq.delete();
      cfg_src_sel_i = 1'b0; cfg_lines_i = 12'd4; cfg_en_i = 1'b1;
      tick(1);
      for (int ln = 0; ln < 4; ln++) begin
         for (int p = 0; p < 2; p++) begin
            if (ln == 2 && p == 1) cfg_src_sel_i = 1'b1;
            send_beat(0, 16'h4000 + 16'(ln * 2 + p), (ln == 0 && p == 0), (p == 1), 1);
         end
      end
      m_tready_i = 1'b0;
      #1;
      n_vec++;
      if ({s0_tready_o, s1_tready_o} !== 2'b10) begin
         n_err++;
         $display("FAIL switch_tready: got s0=%b s1=%b, required 1 0", s0_tready_o, s1_tready_o);
      end
      @(posedge ACLK);
      #1;
      m_tready_i = 1'b1;
      send_beat(0, 16'h40FF, 1, 0, 0);
      send_frame(1, 4, 2, 16'h4100, 1, 3);
      tick(1);
      n_vec++;
      if (mq.size() != 16) begin
         n_err++; $display("FAIL switch_count: got %0d beats, required 16", mq.size());
      end else begin
         foreach (eq[i]) begin
            n_vec++;
            if (mq[i] !== eq[i]) begin
               n_err++; $display("FAIL switch_beat%0d: got %h, required %h", i, mq[i], eq[i]);
            end
         end
      end
   endtask

   task automatic test_short_frame;
      mq.delete(); eq.delete();
      cfg_src_sel_i = 1'b0; cfg_lines_i = 12'd4; cfg_en_i = 1'b1;
      tick(1);
      send_beat(0, 16'h5000, 1, 0, 1);
      send_beat(0, 16'h5001, 0, 1, 1);
      send_beat(0, 16'h5002, 0, 0, 1);
      send_beat(0, 16'h5003, 0, 1, 1);
      send_beat(0, 16'h5100, 1, 0, 1);
      n_vec++;
      if (sts_err_cnt_o !== 8'd1 || sts_frame_cnt_o !== 16'd0) begin
         n_err++;
         $display("FAIL short_err: got err=%0d cnt=%0d, required 1 0", sts_err_cnt_o, sts_frame_cnt_o);
      end
      send_beat(0, 16'h5101, 0, 1, 1);
      for (int ln = 1; ln < 4; ln++) begin
         send_beat(0, 16'h5100 + 16'(2 * ln), 0, 0, 1);
         send_beat(0, 16'h5101 + 16'(2 * ln), 0, 1, 1);
      end
      tick(1);
      n_vec++;
      if (sts_frame_cnt_o !== 16'd1 || mq.size() != 12) begin
         n_err++;
         $display("FAIL short_frame: got cnt=%0d beats=%0d, required 1 12", sts_frame_cnt_o, mq.size());
      end else begin
         foreach (eq[i]) begin
            n_vec++;
            if (mq[i] !== eq[i]) begin
               n_err++; $display("FAIL short_beat%0d: got %h, required %h", i, mq[i], eq[i]);
            end
         end
      end
      // first SOF from WAIT_SOF is a normal frame start, not an error
      send_beat(0, 16'h5200, 1, 0, 0);
      for (int k = 0; k < 253; k++) send_beat(0, 16'h6000 + 16'(k), 1, 0, 0);
      n_vec++;
      if (sts_err_cnt_o !== 8'd254) begin
         n_err++; $display("FAIL short_254: got %0d, required 254", sts_err_cnt_o);
      end
      send_beat(0, 16'h6100, 1, 0, 0);
      n_vec++;
      if (sts_err_cnt_o !== 8'd255) begin
         n_err++; $display("FAIL short_255: got %0d, required 255", sts_err_cnt_o);
      end
      for (int k = 0; k < 46; k++) send_beat(0, 16'h6200 + 16'(k), 1, 0, 0);
      n_vec++;
      if (sts_err_cnt_o !== 8'd255 || sts_frame_cnt_o !== 16'd1) begin
         n_err++;
         $display("FAIL short_sat: got err=%0d cnt=%0d, required 255 1", sts_err_cnt_o, sts_frame_cnt_o);
      end
      tick(1);
      mq.delete(); eq.delete();
   endtask

   task automatic test_random_stall;
      ARESETn = 1'b0;
      tick(2);
      ARESETn = 1'b1;
      n_vec++;
      if (sts_err_cnt_o !== 8'd0 || sts_busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL rand_reset: got err=%0d busy=%b, required 0 0", sts_err_cnt_o, sts_busy_o);
      end
      mq.delete(); eq.delete();
      cfg_src_sel_i = 1'b0; cfg_lines_i = 12'd2; cfg_en_i = 1'b1;
      tick(1);
      g_rand_rdy = 1;
      send_frame(0, 2, 3, 16'h7000, 1, -1);
      send_frame(0, 2, 3, 16'h7100, 1, -1);
      send_frame(0, 2, 3, 16'h7200, 1, 1);
      g_rand_rdy = 0;
      m_tready_i = 1'b1;
      tick(3);
      n_vec++;
      if (mq.size() != 18 || sts_frame_cnt_o !== 16'd3) begin
         n_err++;
         $display("FAIL rand_count: got beats=%0d cnt=%0d, required 18 3", mq.size(), sts_frame_cnt_o);
      end else begin
         foreach (eq[i]) begin
            n_vec++;
            if (mq[i] !== eq[i]) begin
               n_err++; $display("FAIL rand_beat%0d: got %h, required %h", i, mq[i], eq[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_pass;
      cfg_en_i = 1'b1;
      tick(1);
      m_tready_i = 1'b0;
      send_beat(0, 16'h8000, 1, 0, 0);
      s0_tdata_i = 16'h8001; s0_tuser_i = 1'b0; s0_tlast_i = 1'b0; s0_tvalid_i = 1'b1;
      ARESETn = 1'b0;
      tick(1);
      n_vec++;
      if (m_tvalid_o !== 1'b0 || sts_busy_o !== 1'b0 || sts_frame_cnt_o !== 16'd0) begin
         n_err++;
         $display("FAIL rst_mid: got v=%b busy=%b cnt=%0d, required 0 0 0",
                  m_tvalid_o, sts_busy_o, sts_frame_cnt_o);
      end
      ARESETn = 1'b1; cfg_en_i = 1'b0; m_tready_i = 1'b1;
      s0_tdata_i = 16'h8002; s0_tuser_i = 1'b1;
      tick(1);
      n_vec++;
      if (m_tvalid_o !== 1'b0 || sts_busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL rst_after: got v=%b busy=%b, required 0 0", m_tvalid_o, sts_busy_o);
      end
      s0_tvalid_i = 1'b0; s0_tuser_i = 1'b0;
      tick(1);
   endtask

   initial begin
      ARESETn = 1'b0;
      cfg_en_i = 1'b0; cfg_single_i = 1'b0; cfg_src_sel_i = 1'b0;
      cfg_frames_i = 16'd1; cfg_lines_i = 12'd4;
      s0_tdata_i = '0; s0_tvalid_i = 1'b0; s0_tuser_i = 1'b0; s0_tlast_i = 1'b0;
      s1_tdata_i = '0; s1_tvalid_i = 1'b0; s1_tuser_i = 1'b0; s1_tlast_i = 1'b0;
      m_tready_i = 1'b1;
      test_reset();
      test_continuous();
      test_single();
      test_mid_enable();
      test_src_switch();
      test_short_frame();
      test_random_stall();
      test_reset_mid_pass();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/video_frame_sched.md
VIDEO_FRAME_SCHED -- requirements
Module: video_frame_sched

Interface
REQ-001 Parameter DW, default 16, SHALL set the AXI4-stream video TDATA width.
REQ-002 Parameter LW, default 12, SHALL set the line-count width.
REQ-003 ACLK  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 ARESETn  in  1  SHALL be the synchronous, active-low reset.
REQ-005 cfg_en_i  in  1  run enable (level).
REQ-006 cfg_single_i  in  1  mode: 1 = single-shot of cfg_frames_i frames, 0 = continuous.
REQ-007 cfg_src_sel_i  in  1  source select: 0 = pattern generator (s0), 1 = BT656 receiver (s1).
REQ-008 cfg_frames_i  in  16  frames per single-shot; 0 is treated as 1.
REQ-009 cfg_lines_i  in  LW  lines per frame; 0 is treated as 1.
REQ-010 s0_tdata_i/s0_tvalid_i/s0_tuser_i/s0_tlast_i  in  DW/1/1/1; s0_tready_o  out  1: pattern source slave.
REQ-011 s1_tdata_i/s1_tvalid_i/s1_tuser_i/s1_tlast_i  in  DW/1/1/1; s1_tready_o  out  1: sensor source slave.
REQ-012 m_tdata_o/m_tvalid_o/m_tuser_o/m_tlast_o  out  DW/1/1/1; m_tready_i  in  1: video master output (tuser = SOF, tlast = EOL).
REQ-013 sts_busy_o  out  1  high in any state other than IDLE.
REQ-014 sts_frame_cnt_o  out  16  completed frames forwarded since enable rose; wraps.
REQ-015 sts_err_cnt_o  out  8  short-frame count; saturates at 255.
REQ-016 sts_done_o  out  1  one-cycle pulse when a single-shot completes.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_SOF, PASS, HOLD.
REQ-018 IDLE -> WAIT_SOF on a cycle with cfg_en_i=1; sel, single, frames and lines SHALL be latched on this transition; frame_cnt cleared.
REQ-019 WAIT_SOF: selected-source beats with tuser=0 SHALL be accepted and dropped; the first accepted beat with tuser=1 SHALL be forwarded and move the FSM to PASS with line_cnt=0.
REQ-020 PASS: every selected-source beat SHALL be forwarded; each forwarded tlast SHALL increment line_cnt.
REQ-021 Frame end is the forwarded tlast beat with line_cnt = latched lines-1; at that beat frame_cnt increments.
REQ-022 At frame end: if cfg_en_i=0 -> IDLE; else if single and frame_cnt+1 = frames -> HOLD with sts_done_o pulsed; else -> WAIT_SOF with cfg_src_sel_i re-latched.
REQ-023 HOLD SHALL remain until cfg_en_i=0, then go to IDLE; no beats are forwarded.
REQ-024 A tuser=1 beat arriving in PASS before frame end (short frame) SHALL increment sts_err_cnt_o, be forwarded as a new SOF, and reset line_cnt to 0; frame_cnt is unchanged.
REQ-025 cfg_en_i or cfg_src_sel_i changes mid-frame SHALL take effect only at frame end.
REQ-026 The non-selected source, and the selected source in IDLE/HOLD, SHALL see tready=1 (free-running discard; sources never stall).
REQ-027 Output SHALL be a single register stage: latency 1 cycle; selected tready = !m_tvalid_o || m_tready_i.
REQ-028 m_tvalid_o SHALL stay high with tdata/tuser/tlast stable until m_tready_i=1.
REQ-029 Forwarded-beat state updates (line_cnt, frame end) SHALL occur on the input-acceptance cycle, not the output-handshake cycle.

Reset
REQ-030 While ARESETn=0 at a clock edge: state=IDLE; m_tvalid_o, m_tuser_o, m_tlast_o, sts_done_o=0; m_tdata_o=0; counters=0; sts_busy_o=0.
REQ-031 Reset mid-frame SHALL abort immediately; the first beat after reset is treated as in IDLE.

Structure
REQ-032 The state enum, the DW/LW defaults and the source-select encoding SHALL live in the shared package video_ctrl_pkg.
REQ-033 The output register stage SHALL be the sub-module video_axis_reg (DW-parameterized); the FSM and counters stay in video_frame_sched.

Verification
REQ-034 Continuous, lines=4, s0 4-line frames, tready=1 -> all beats out 1 cycle late, frame_cnt 1,2,3,..., err_cnt 0.
REQ-035 Single, frames=2, en held -> exactly 2 frames forwarded, sts_done_o pulse on 2nd frame's last tlast, HOLD, busy=1 until en=0.
REQ-036 Enable mid-frame on s1 -> beats dropped until next tuser=1; first m beat has m_tuser_o=1.
REQ-037 src_sel 0->1 during line 2 of 4 -> rest of s0 frame forwarded, next frame from s1 SOF; s0 tready stays 1.
REQ-038 tuser=1 at line 2 of 4 -> err_cnt=1, new frame forwarded, frame_cnt unchanged; 300 short frames -> err_cnt=255.
REQ-039 Random m_tready_i 50% -> no beat lost or duplicated, output stable while stalled; reset mid-PASS -> m_tvalid_o=0 next cycle, state IDLE.
